ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter; sends command bytes (LED set 0xED, reset 0xFF, ...) to keyboard or mouse.
//  Pairs with the existing PS/2 receivers on the same ps2k/ps2m open-drain lines.
//  Top level muxes its drive-low enables onto the inout pins; the receiver stays idle while busy=1.
// PARAMETERS
//  CLKHZ       56000000  system clock frequency, Hz
//  INHIBIT_US  100       clock-inhibit time before the request-to-send, us
//  TIMEOUT_MS  15        whole-transfer watchdog, ms (only with PS2TX_TIMEOUT_EN)
//  FILT        8         glitch filter depth on ps2 clock input, cycles
// PORTS
//  clock     in   1  system clock
//  reset     in   1  synchronous, active-low reset
//  strb      in   1  1-cycle request; data latched when accepted
//  data      in   8  byte to send
//  busy      out  1  transfer in progress
//  done      out  1  1-cycle pulse at end of every accepted transfer
//  err       out  1  1-cycle pulse with done: no ACK or timeout
//  ps2ClkI   in   1  ps2 clock pin level (asynchronous)
//  ps2DatI   in   1  ps2 data pin level (asynchronous)
//  ps2ClkOe  out  1  1 = drive clock pin low
//  ps2DatOe  out  1  1 = drive data pin low
// BEHAVIOUR
//  Reset (reset=0 at a clock edge): state IDLE; busy, done, err, ps2ClkOe, ps2DatOe all 0 by the next edge, including mid-transfer.
//  Inputs: 2-FF synchroniser each. Clock then passes an FILT-deep filter that changes only after FILT equal samples.
//  fall = filtered clock 1->0, 1-cycle pulse.
//  IDLE: strb=1 -> latch data, par = ~^data (odd parity), cnt=0, busy=1, go INHIBIT on the next edge. strb while busy is ignored.
//  INHIBIT: ps2ClkOe=1 for CLKHZ/1e6*INHIBIT_US cycles.
//   Last cycle: ps2DatOe=1 (start bit).
//   Then REQ: ps2ClkOe=0, ps2DatOe stays 1.
//  REQ/DATA: each fall increments cnt and sets the data line for the next bit. Device samples on its rising edge.
//   fall 1..8: ps2DatOe = ~data[cnt-1] (LSB first).
//   fall 9: ps2DatOe = ~par.
//   fall 10: ps2DatOe = 0 (stop bit, line released).
//  ACK: on fall 11, sample synchronised data. 0 = ack ok; 1 = nack, err=1.
//   Then WAITIDLE.
//  WAITIDLE: wait until filtered clock=1 and data=1 for 1 cycle.
//   Then done=1 (err alongside if nack), busy=0, IDLE.
//   done and err are registered: they assert on the edge after the event and last exactly 1 cycle.
//  Never drive a pin high: Oe outputs only.
//  ps2ClkOe is 1 only in INHIBIT. ps2DatOe is 0 in IDLE, ACK, WAITIDLE.
//  A fall seen in INHIBIT (device still talking) is ignored; INHIBIT timing is unaffected.
// CONFIGURATION
//  `define PS2TX_TIMEOUT_EN
//   With it: a watchdog counts from leaving INHIBIT.
//    After CLKHZ/1000*TIMEOUT_MS cycles in REQ/DATA/ACK/WAITIDLE: release both lines, done=1, err=1, busy=0, IDLE.
//   Without it: no watchdog. A missing device holds busy=1 until reset.
// STRUCTURE
//  Shared package/include (ps2_defs): state encodings IDLE, INHIBIT, REQ, DATA, ACK, WAITIDLE.
//   Also: bit-index constants for the 11-frame positions (PAR=9, STOP=10, ACK=11).
//  Sub-module ps2_filter (synchroniser + FILT-deep filter + fall pulse), reused by the PS/2 receivers.
//  Counters: cnt 4 bits; inhibit counter $clog2(CLKHZ/1e6*INHIBIT_US+1); watchdog $clog2(CLKHZ/1000*TIMEOUT_MS+1).
// TESTING
//  Bench: device model with 12.5 kHz clock; CLKHZ=1000000, INHIBIT_US=100, TIMEOUT_MS=2, FILT=4.
//  1 Send 0xED, device acks
//    -> ps2ClkOe=1 for 100 cycles, start bit 0.
//    -> Device samples 1,0,1,1,0,1,1,1, parity 1, stop 1.
//    -> done=1, err=0, busy=0 after idle.
//  2 Send 0x00, device leaves data high at ack -> data bits all 0, parity 1, done=1 and err=1 together.
//  3 strb while busy (data=0x55) -> ignored. Device receives only the first byte 0xFF; exactly one done.
//  4 reset=0 during DATA at fall 5 -> next edge: ps2ClkOe=0, ps2DatOe=0, busy=0, no done pulse.
//    Following strb with 0xF4 transfers correctly.
//  5 2-cycle glitch low on ps2ClkI during DATA -> no fall counted; byte received intact.
//  6 PS2TX_TIMEOUT_EN, device silent after inhibit -> at 2000 cycles: done=1, err=1, both Oe 0.
//    Without the macro: busy stays 1.

Source files
------------

// File: rtl/ps2_defs_pkg.sv
// Shared PS/2 definitions: transmitter state encodings, frame bit positions, parity helper.
package ps2_defs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_REQ      = 3'd2,
        ST_DATA     = 3'd3,
        ST_ACK      = 3'd4,
        ST_WAITIDLE = 3'd5
    } ps2_state_e;

    // Falling-edge index at which each frame position is driven or sampled
    localparam logic [3:0] FRAME_PAR  = 4'd9;
    localparam logic [3:0] FRAME_STOP = 4'd10;
    localparam logic [3:0] FRAME_ACK  = 4'd11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 pin conditioning: 2-FF synchronisers on clock and data, FILT-deep clock
// filter and a one-cycle pulse on each filtered clock falling edge.
module ps2_filter #(
    parameter int FILT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clk_pin_i,
    input  logic dat_pin_i,
    output logic clk_filt_o,
    output logic dat_sync_o,
    output logic fall_o
);

    localparam int CW = (FILT > 1) ? $clog2(FILT + 1) : 1;

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          clk_filt_q;
    logic          fall_q;
    logic [CW-1:0] flt_cnt_q;

    // Filtered clock flips only after FILT consecutive samples disagree with it
    always_ff @(posedge clock) begin
        if (!reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_filt_q <= 1'b1;
            flt_cnt_q  <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], clk_pin_i};
            dat_sync_q <= {dat_sync_q[0], dat_pin_i};
            fall_q     <= 1'b0;
            if (clk_sync_q[1] == clk_filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == CW'(FILT - 1)) begin
                flt_cnt_q  <= '0;
                clk_filt_q <= clk_sync_q[1];
                fall_q     <= clk_filt_q;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    assign clk_filt_o = clk_filt_q;
    assign dat_sync_o = dat_sync_q[1];
    assign fall_o     = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter driving open-drain enables only.
// Optional transfer watchdog enabled by `define PS2TX_TIMEOUT_EN.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | waiting for strb, lines released
// ST_INHIBIT  | clock held low; start bit asserted on the last cycle
// ST_REQ      | clock released, start bit on data, awaiting first fall
// ST_DATA     | shifting data bits, parity and stop on each fall
// ST_ACK      | data released, sampling device ack on fall 11
// ST_WAITIDLE | waiting for clock and data both high before done
module ps2_host_tx
    import ps2_defs_pkg::*;
#(
    parameter int CLKHZ      = 56000000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15,
    parameter int FILT       = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       strb,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2ClkI,
    input  logic       ps2DatI,
    output logic       ps2ClkOe,
    output logic       ps2DatOe
);

    localparam int INH_CYC = CLKHZ / 1000000 * INHIBIT_US;
    localparam int INH_W   = $clog2(INH_CYC + 1);
    localparam int WD_CYC  = CLKHZ / 1000 * TIMEOUT_MS;
    localparam int WD_W    = $clog2(WD_CYC + 1);

`ifdef PS2TX_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic clk_filt;
    logic dat_sync;
    logic fall;

    ps2_filter #(.FILT(FILT)) u_filter (
        .clock      (clock),
        .reset      (reset),
        .clk_pin_i  (ps2ClkI),
        .dat_pin_i  (ps2DatI),
        .clk_filt_o (clk_filt),
        .dat_sync_o (dat_sync),
        .fall_o     (fall)
    );

    ps2_state_e       state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       cnt_nx;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             nack_q, nack_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            par_q    <= 1'b0;
            cnt_q    <= '0;
            inh_q    <= '0;
            wd_q     <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            par_q    <= par_d;
            cnt_q    <= cnt_d;
            inh_q    <= inh_d;
            wd_q     <= wd_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            nack_q   <= nack_d;
        end
    end

    assign cnt_nx = cnt_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        par_d    = par_q;
        cnt_d    = cnt_q;
        inh_d    = inh_q;
        wd_d     = wd_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        nack_d   = nack_q;

        unique case (state_q)
            ST_IDLE: begin
                if (strb) begin
                    data_d   = data;
                    par_d    = odd_parity(data);
                    cnt_d    = '0;
                    nack_d   = 1'b0;
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    dat_oe_d = (INH_CYC == 1);
                    inh_d    = INH_W'(INH_CYC - 1);
                    state_d  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                // Falls here are our own inhibit or a device still talking; ignored
                if (inh_q == '0) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    wd_d     = WD_W'(WD_CYC - 1);
                    state_d  = ST_REQ;
                end else begin
                    inh_d    = inh_q - 1'b1;
                    dat_oe_d = (inh_q == INH_W'(1));
                end
            end
            ST_REQ, ST_DATA: begin
                if (fall) begin
                    cnt_d   = cnt_nx;
                    state_d = ST_DATA;
                    if (cnt_nx < FRAME_PAR) begin
                        dat_oe_d = ~data_q[cnt_q[2:0]];
                    end else if (cnt_nx == FRAME_PAR) begin
                        dat_oe_d = ~par_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (fall) begin
                    cnt_d   = cnt_nx;
                    nack_d  = dat_sync;
                    state_d = ST_WAITIDLE;
                end
            end
            ST_WAITIDLE: begin
                if (clk_filt && dat_sync) begin
                    done_d  = 1'b1;
                    err_d   = nack_q;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase

        if (WD_EN && (state_q inside {ST_REQ, ST_DATA, ST_ACK, ST_WAITIDLE})) begin
            if (wd_q == '0) begin
                state_d  = ST_IDLE;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                err_d    = 1'b1;
            end else begin
                wd_d = wd_q - 1'b1;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign ps2ClkOe = clk_oe_q;
    assign ps2DatOe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a 12.5 kHz device model that records
// each frame, plus a per-cycle monitor of busy/done/err and the line enables.
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int TMO = 2000;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       strb  = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       busy, done, err, ps2ClkOe, ps2DatOe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2ClkI, ps2DatI;

    assign ps2ClkI = dev_clk & ~ps2ClkOe;
    assign ps2DatI = dev_dat & ~ps2DatOe;

    always #5 clock = ~clock;

    ps2_host_tx #(
        .CLKHZ(1000000), .INHIBIT_US(100), .TIMEOUT_MS(2), .FILT(4)
    ) dut (
        .clock(clock), .reset(reset), .strb(strb), .data(data),
        .busy(busy), .done(done), .err(err),
        .ps2ClkI(ps2ClkI), .ps2DatI(ps2DatI),
        .ps2ClkOe(ps2ClkOe), .ps2DatOe(ps2DatOe)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic model_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2) == 0;
    endfunction

    // Device model
    logic       dev_present = 1'b1;
    logic       dev_ack     = 1'b1;
    int         glitch_k    = 0;
    int         dev_falls   = 0;
    bit         dev_busy    = 1'b0;
    int         rx_cnt      = 0;
    logic       rx_start    = 1'b1;
    logic [7:0] rx_byte     = 8'h00;
    logic       rx_par      = 1'b0;
    logic       rx_stop     = 1'b0;

    initial begin
        forever begin
            @(negedge clock iff ps2ClkOe === 1'b1);
            @(negedge clock iff ps2ClkOe === 1'b0);
            repeat (5) @(negedge clock);
            rx_start = ps2DatI;
            if (dev_present) begin
                dev_busy  = 1'b1;
                dev_falls = 0;
                repeat (40) @(negedge clock);
                for (int k = 1; k <= 11; k++) begin
                    dev_clk   = 1'b0;
                    dev_falls = k;
                    if (k == 11 && dev_ack) dev_dat = 1'b0;
                    repeat (40) @(negedge clock);
                    dev_clk = 1'b1;
                    if (k <= 8)       rx_byte[k-1] = ps2DatI;
                    else if (k == 9)  rx_par  = ps2DatI;
                    else if (k == 10) rx_stop = ps2DatI;
                    else              dev_dat = 1'b1;
                    if (k == glitch_k) begin
                        repeat (20) @(negedge clock);
                        dev_clk = 1'b0;
                        repeat (2) @(negedge clock);
                        dev_clk = 1'b1;
                        repeat (18) @(negedge clock);
                    end else begin
                        repeat (40) @(negedge clock);
                    end
                end
                rx_cnt++;
                dev_busy = 1'b0;
            end
        end
    end

    // Per-cycle monitor against the transfer model
    int   cyc            = 0;
    bit   mon_en         = 1'b0;
    bit   model_busy     = 1'b0;
    logic exp_err_q[$];
    int   done_cnt       = 0;
    int   inh_run        = 0;
    int   last_inh_len   = 0;
    int   clkoe_fall_cyc = 0;
    int   done_cyc       = 0;
    logic last_err       = 1'b0;
    logic prev_clkoe     = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (mon_en) begin
            chk("busy", busy, done ? 1'b0 : model_busy);
            if (!busy) chk("idle_lines", {ps2ClkOe, ps2DatOe}, 2'b00);
            if (err) chk("err_with_done", done, 1'b1);
            if (ps2ClkOe) begin
                chk("start_bit_timing", ps2DatOe, inh_run == INH - 1);
                inh_run++;
            end else begin
                if (prev_clkoe) begin
                    last_inh_len   = inh_run;
                    clkoe_fall_cyc = cyc;
                end
                inh_run = 0;
            end
            prev_clkoe = ps2ClkOe;
            if (done) begin
                done_cnt++;
                done_cyc   = cyc;
                last_err   = err;
                model_busy = 1'b0;
                if (exp_err_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    chk("err_on_done", err, exp_err_q.pop_front());
                end
            end
            if (!reset) begin
                model_busy = 1'b0;
                exp_err_q.delete();
            end else if (strb && !model_busy) begin
                model_busy = 1'b1;
                exp_err_q.push_back(!dev_present || !dev_ack);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clock); #1;
        strb = 1'b1;
        data = b;
        @(posedge clock); #1;
        strb = 1'b0;
    endtask

    task automatic wait_done(input int n_before, input string nm);
        int t = 0;
        while (done_cnt == n_before && t < 4000) begin
            @(negedge clock);
            t++;
        end
        @(negedge clock);
        chk(nm, done_cnt - n_before, 1);
    endtask

    task automatic wait_dev_idle(input string nm);
        int t = 0;
        repeat (2) @(negedge clock);
        while (dev_busy && t < 2000) begin
            @(negedge clock);
            t++;
        end
        chk(nm, dev_busy, 1'b0);
    endtask

    task automatic chk_frame(input string nm, input logic [7:0] exp_b, input logic exp_par);
        chk({nm, "_start"}, rx_start, 1'b0);
        chk({nm, "_byte"}, rx_byte, exp_b);
        chk({nm, "_par"}, rx_par, exp_par);
        chk({nm, "_par_model"}, rx_par, model_par(exp_b));
        chk({nm, "_stop"}, rx_stop, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n, r, t;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_clkoe", ps2ClkOe, 1'b0);
        chk("rst_datoe", ps2DatOe, 1'b0);
        mon_en = 1'b1;

        // 1: 0xED with ack
        dev_present = 1'b1; dev_ack = 1'b1;
        n = done_cnt; r = rx_cnt;
        send(8'hED);
        wait_done(n, "t1_done");
        chk("t1_err", last_err, 1'b0);
        chk("t1_inhibit_len", last_inh_len, INH);
        wait_dev_idle("t1_dev_idle");
        chk("t1_rx_count", rx_cnt - r, 1);
        chk_frame("t1", 8'hED, 1'b1);
        chk("t1_busy_after", busy, 1'b0);

        // 2: 0x00, device nacks
        dev_ack = 1'b0;
        n = done_cnt;
        send(8'h00);
        wait_done(n, "t2_done");
        chk("t2_err", last_err, 1'b1);
        wait_dev_idle("t2_dev_idle");
        chk_frame("t2", 8'h00, 1'b1);
        dev_ack = 1'b1;

        // 3: second strb while busy is ignored
        n = done_cnt; r = rx_cnt;
        send(8'hFF);
        repeat (30) @(negedge clock);
        send(8'h55);
        wait_done(n, "t3_done");
        wait_dev_idle("t3_dev_idle");
        repeat (300) @(negedge clock);
        chk("t3_single_done", done_cnt - n, 1);
        chk("t3_single_rx", rx_cnt - r, 1);
        chk_frame("t3", 8'hFF, 1'b1);

        // 4: reset mid-frame after fall 5, then a clean transfer
        n = done_cnt;
        send(8'h3C);
        t = 0;
        while (dev_falls != 5 && t < 2000) begin
            @(negedge clock);
            t++;
        end
        chk("t4_reach_fall5", dev_falls, 5);
        repeat (10) @(negedge clock);
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        chk("t4_rst_clkoe", ps2ClkOe, 1'b0);
        chk("t4_rst_datoe", ps2DatOe, 1'b0);
        chk("t4_rst_busy", busy, 1'b0);
        wait_dev_idle("t4_dev_idle");
        chk("t4_no_done", done_cnt - n, 0);
        n = done_cnt;
        send(8'hF4);
        wait_done(n, "t4_done");
        chk("t4_err", last_err, 1'b0);
        wait_dev_idle("t4b_dev_idle");
        chk_frame("t4", 8'hF4, 1'b0);

        // 5: 2-cycle clock glitch during data is rejected
        glitch_k = 3;
        n = done_cnt;
        send(8'hA5);
        wait_done(n, "t5_done");
        wait_dev_idle("t5_dev_idle");
        chk_frame("t5", 8'hA5, 1'b1);
        glitch_k = 0;

        // 6: silent device
        dev_present = 1'b0;
        n = done_cnt;
        send(8'h12);
`ifdef PS2TX_TIMEOUT_EN
        wait_done(n, "t6_done");
        chk("t6_err", last_err, 1'b1);
        chk("t6_timeout_cycles", done_cyc - clkoe_fall_cyc, TMO);
        chk("t6_lines", {ps2ClkOe, ps2DatOe}, 2'b00);
        chk("t6_busy", busy, 1'b0);
`else
        repeat (2500) @(negedge clock);
        chk("t6_busy_held", busy, 1'b1);
        chk("t6_no_done", done_cnt - n, 0);
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        chk("t6_rst_busy", busy, 1'b0);
`endif
        dev_present = 1'b1;
        repeat (5) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
